bsg_level_shift_iso_ctrl: RTL and testbench
===========================================

Name: bsg_level_shift_iso_ctrl

Overview:
- Power-domain sequencer for a bank of bsg level-shift source cells.
- Drives the power-switch enable and the shared level-shifter/isolation enable (v0_en) of a switchable domain.
- Guarantees isolation stays active until the domain's power is good and settled, and re-engages before power is removed.
- Sits in the always-on domain beside the level-shift source bank it controls.

Parameters:
- settle_cycles_p, 8: cycles after pg_i rises before isolation releases; must be >= 1.
- drain_cycles_p, 4: cycles isolation is held with power still on before power-off; must be >= 1.
- timeout_cycles_p, 255: cycles allowed for a pg_i transition; used only with the optional feature.

Ports:
- clk_i  in  1  sole clock.
- reset_i  in  1  asynchronous, active-high reset.
- on_req_i  in  1  level request: 1 = domain wanted on.
- pg_i  in  1  power-good from the switch, already synchronized to clk_i.
- err_clr_i  in  1  clears the error state.
- pwr_en_o  out  1  power-switch enable.
- v0_en_o  out  1  level-shifter enable; 0 = isolated, outputs forced low.
- on_o  out  1  domain usable.
- busy_o  out  1  sequence in progress.
- err_o  out  1  error latched.

Behaviour:
Clock and reset:
- One clock; reset is asynchronous and active-high.
- reset_i forces state OFF and counter 0.
- All outputs go to 0 immediately, including pwr_en_o, whatever the current state (reset mid-operation cuts power and isolates).
- Outputs are Moore, decoded from the registered state.

Counter:
- Single down-counter, width $clog2(max(settle_cycles_p, drain_cycles_p, timeout_cycles_p)+1).
- Loaded on state entry as listed below.

States (pwr_en / v0_en / on / busy / err):
- OFF (0/0/0/0/0): on_req_i=1 -> PWR_UP.
- PWR_UP (1/0/0/1/0):
  - on_req_i=0 -> PWR_DN; this has priority and skips DRAIN, since isolation was never released.
  - Else pg_i=1 -> SETTLE, counter loaded with settle_cycles_p-1.
- SETTLE (1/0/0/1/0):
  - on_req_i=0 -> PWR_DN.
  - Else pg_i=0 -> PWR_UP (glitch restarts the wait).
  - Else counter==0 -> ON.
  - Else decrement.
- ON (1/1/1/0/0):
  - pg_i=0 -> ERR; this has priority over on_req_i.
  - Else on_req_i=0 -> DRAIN, counter loaded with drain_cycles_p-1.
- DRAIN (1/0/0/1/0):
  - counter==0 -> PWR_DN; else decrement.
  - on_req_i is ignored; a down-sequence is never aborted.
  - pg_i loss -> ERR.
- PWR_DN (0/0/0/1/0): pg_i=0 -> OFF.
- ERR (0/0/0/0/1):
  - err_clr_i=1 -> OFF.
  - err_clr_i is ignored in all other states.
  - A re-request after clear starts a fresh power-up.

Invariants and timing:
- v0_en_o=1 only in ON, hence only while pwr_en_o=1 and pg_i was 1 on the prior edge.
- Latency: pg_i sampled high at edge k gives SETTLE at k, ON at k+settle_cycles_p.
- From ON with on_req_i sampled low at edge m: v0_en_o falls at m, pwr_en_o falls at m+drain_cycles_p.
- If on_req_i is still 1 on reaching OFF, the next edge starts PWR_UP (no extra idle cycle required).

Optional Feature:
BSG_LEVEL_SHIFT_ISO_CTRL_TIMEOUT_EN
- Defined:
  - Counter is loaded with timeout_cycles_p-1 on entry to PWR_UP (including the re-entry from SETTLE) and to PWR_DN.
  - Each cycle without the awaited pg_i level decrements it.
  - Expiry at 0 -> ERR.
  - A pg_i event and a timeout on the same edge: the pg_i event wins.
- Undefined: PWR_UP and PWR_DN wait indefinitely, and timeout_cycles_p has no effect.

Test Plan:
1. Reset with on_req_i=1 and pg_i=1 asserted mid-ON -> all outputs 0 asynchronously; after release, PWR_UP next edge.
2. Defaults: on_req_i=1 at edge 1, pg_i=1 from edge 4 -> pwr_en_o=1 after edge 1, v0_en_o=1/on_o=1 after edge 12, busy_o=1 over edges 1-11.
3. From ON, on_req_i=0 at edge 20 -> v0_en_o=0 after 20, pwr_en_o=0 after 24; pg_i=0 at 26 -> OFF and busy_o=0 after 26; on_req_i=1 during 21-23 has no effect.
4. pg_i pulses low 1 cycle at SETTLE count 3 -> back to PWR_UP, full 8-cycle settle re-run, v0_en_o never asserts early.
5. pg_i drops in ON -> v0_en_o, pwr_en_o, on_o = 0 and err_o=1 after same edge; err_clr_i=1 -> OFF next edge with err_o=0.
6. With macro, timeout_cycles_p=16, pg_i held 0 -> ERR 16 edges after PWR_UP entry; without macro -> remains PWR_UP after 1000 cycles.

Source files
------------

// File: rtl/bsg_level_shift_iso_ctrl_if.sv
// bsg_level_shift_iso_ctrl_if
//   Bundles the request/status signals of the power-domain sequencer.
//   master : the sequencer (drives the power/isolation controls and status)
//   slave  : the environment (drives the request, power-good and error clear)
//   Signals:
//     on_req_i  level request, 1 = domain wanted on
//     pg_i      power-good from the switch, already synchronous to the clock
//     err_clr_i clears a latched error
//     pwr_en_o  power-switch enable
//     v0_en_o   level-shifter/isolation enable (0 = isolated)
//     on_o      domain usable
//     busy_o    power sequence in progress
//     err_o     error latched
//     dbg_state current sequencer state, for observation only
interface bsg_level_shift_iso_ctrl_if;
   logic       on_req_i;
   logic       pg_i;
   logic       err_clr_i;
   logic       pwr_en_o;
   logic       v0_en_o;
   logic       on_o;
   logic       busy_o;
   logic       err_o;
   logic [2:0] dbg_state;

   modport master (
      input  on_req_i, pg_i, err_clr_i,
      output pwr_en_o, v0_en_o, on_o, busy_o, err_o, dbg_state
   );

   modport slave (
      output on_req_i, pg_i, err_clr_i,
      input  pwr_en_o, v0_en_o, on_o, busy_o, err_o, dbg_state
   );
endinterface

// File: rtl/bsg_level_shift_iso_ctrl.sv
// bsg_level_shift_iso_ctrl
//   Always-on sequencer for a switchable power domain fed through a bank of
//   bsg level-shift source cells. Keeps isolation (v0_en_o = 0) engaged until
//   power is good and settled, and re-engages it before power is removed.
//   Ports:
//     clk_i    sole clock
//     reset_i  asynchronous active-high reset; cuts power and isolates at once
//     bus      bsg_level_shift_iso_ctrl_if.master (request/status bundle)
//   Optional feature (macro BSG_LEVEL_SHIFT_ISO_CTRL_TIMEOUT_EN):
//     when defined, PWR_UP and PWR_DN give up after timeout_cycles_p cycles
//     without the awaited pg_i level and enter ERR; otherwise they wait forever.
//   Outputs are Moore, decoded from the registered state only.
module bsg_level_shift_iso_ctrl #(
   parameter int settle_cycles_p  = 8,
   parameter int drain_cycles_p   = 4,
   parameter int timeout_cycles_p = 255
) (
   input logic                           clk_i,
   input logic                           reset_i,
   bsg_level_shift_iso_ctrl_if.master    bus
);

   localparam int max_a_lp  = (settle_cycles_p > drain_cycles_p) ? settle_cycles_p : drain_cycles_p;
   localparam int max_lp    = (max_a_lp > timeout_cycles_p) ? max_a_lp : timeout_cycles_p;
   localparam int cnt_w_lp  = $clog2(max_lp + 1);

   localparam logic [cnt_w_lp-1:0] settle_load_lp = cnt_w_lp'(settle_cycles_p - 1);
   localparam logic [cnt_w_lp-1:0] drain_load_lp  = cnt_w_lp'(drain_cycles_p - 1);
`ifdef BSG_LEVEL_SHIFT_ISO_CTRL_TIMEOUT_EN
   localparam logic [cnt_w_lp-1:0] timeout_load_lp = cnt_w_lp'(timeout_cycles_p - 1);
`endif

   typedef enum logic [2:0] {
      off_s    = 3'd0,
      pwr_up_s = 3'd1,
      settle_s = 3'd2,
      on_s     = 3'd3,
      drain_s  = 3'd4,
      pwr_dn_s = 3'd5,
      err_s    = 3'd6
   } state_e;

   state_e              state, state_nxt;
   logic [cnt_w_lp-1:0] cnt, cnt_nxt;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state <= off_s;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next-state and counter update. The counter is reloaded only on entry to
   // a timed state; otherwise it holds or counts down.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      unique case (state)
         off_s: begin
            if (bus.on_req_i) begin
               state_nxt = pwr_up_s;
`ifdef BSG_LEVEL_SHIFT_ISO_CTRL_TIMEOUT_EN
               cnt_nxt   = timeout_load_lp;
`endif
            end
         end
         pwr_up_s: begin
            // Dropping the request wins and skips DRAIN: isolation never opened.
            if (!bus.on_req_i) begin
               state_nxt = pwr_dn_s;
`ifdef BSG_LEVEL_SHIFT_ISO_CTRL_TIMEOUT_EN
               cnt_nxt   = timeout_load_lp;
`endif
            end else if (bus.pg_i) begin
               state_nxt = settle_s;
               cnt_nxt   = settle_load_lp;
            end
`ifdef BSG_LEVEL_SHIFT_ISO_CTRL_TIMEOUT_EN
            else if (cnt == '0) begin
               state_nxt = err_s;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
`endif
         end
         settle_s: begin
            if (!bus.on_req_i) begin
               state_nxt = pwr_dn_s;
`ifdef BSG_LEVEL_SHIFT_ISO_CTRL_TIMEOUT_EN
               cnt_nxt   = timeout_load_lp;
`endif
            end else if (!bus.pg_i) begin
               // A power-good glitch restarts the whole wait.
               state_nxt = pwr_up_s;
`ifdef BSG_LEVEL_SHIFT_ISO_CTRL_TIMEOUT_EN
               cnt_nxt   = timeout_load_lp;
`endif
            end else if (cnt == '0) begin
               state_nxt = on_s;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         on_s: begin
            if (!bus.pg_i) begin
               state_nxt = err_s;
            end else if (!bus.on_req_i) begin
               state_nxt = drain_s;
               cnt_nxt   = drain_load_lp;
            end
         end
         drain_s: begin
            // A down-sequence is never aborted by a new request.
            if (!bus.pg_i) begin
               state_nxt = err_s;
            end else if (cnt == '0) begin
               state_nxt = pwr_dn_s;
`ifdef BSG_LEVEL_SHIFT_ISO_CTRL_TIMEOUT_EN
               cnt_nxt   = timeout_load_lp;
`endif
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         pwr_dn_s: begin
            if (!bus.pg_i) begin
               state_nxt = off_s;
            end
`ifdef BSG_LEVEL_SHIFT_ISO_CTRL_TIMEOUT_EN
            else if (cnt == '0) begin
               state_nxt = err_s;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
`endif
         end
         err_s: begin
            if (bus.err_clr_i) begin
               state_nxt = off_s;
            end
         end
         default: begin
            state_nxt = off_s;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Moore output decode. v0_en_o is high only in ON.
   always_comb begin
      bus.pwr_en_o = 1'b0;
      bus.v0_en_o  = 1'b0;
      bus.on_o     = 1'b0;
      bus.busy_o   = 1'b0;
      bus.err_o    = 1'b0;
      unique case (state)
         pwr_up_s, settle_s, drain_s: begin
            bus.pwr_en_o = 1'b1;
            bus.busy_o   = 1'b1;
         end
         on_s: begin
            bus.pwr_en_o = 1'b1;
            bus.v0_en_o  = 1'b1;
            bus.on_o     = 1'b1;
         end
         pwr_dn_s: bus.busy_o = 1'b1;
         err_s:    bus.err_o  = 1'b1;
         default: ;
      endcase
   end

   assign bus.dbg_state = state;

endmodule

// File: tb/tb_bsg_level_shift_iso_ctrl.sv
// tb_bsg_level_shift_iso_ctrl
//   Table-driven bench for bsg_level_shift_iso_ctrl. Each record gives the
//   inputs held across one rising edge and the outputs expected just after it,
//   packed as {pwr_en, v0_en, on, busy, err}. Hand-written sequences cover
//   asynchronous reset mid-ON and the pg_i timeout behaviour.
module tb_bsg_level_shift_iso_ctrl;

   typedef struct {
      logic       on_req;
      logic       pg;
      logic       clr;
      logic [4:0] exp;
   } vec_t;

   localparam logic [4:0] o_off  = 5'b00000;
   localparam logic [4:0] o_busy = 5'b10010;  // PWR_UP / SETTLE / DRAIN
   localparam logic [4:0] o_on   = 5'b11100;
   localparam logic [4:0] o_dn   = 5'b00010;
   localparam logic [4:0] o_err  = 5'b00001;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   vec_t vecs[$];

   bsg_level_shift_iso_ctrl_if bus ();

   bsg_level_shift_iso_ctrl #(
      .settle_cycles_p  (8),
      .drain_cycles_p   (4),
      .timeout_cycles_p (16)
   ) dut (
      .clk_i   (clk),
      .reset_i (rst),
      .bus     (bus)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [4:0] outs();
      return {bus.pwr_en_o, bus.v0_en_o, bus.on_o, bus.busy_o, bus.err_o};
   endfunction

   task automatic chk(input string nm, input logic [4:0] act, input logic [4:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: outputs {pwr_en,v0_en,on,busy,err} got %05b expected %05b",
                  nm, act, exp);
      end
   endtask

   task automatic drive(input logic on_req, input logic pg, input logic clr);
      bus.on_req_i  = on_req;
      bus.pg_i      = pg;
      bus.err_clr_i = clr;
   endtask

   // one rising edge, then settle away from the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic void add(input logic on_req, input logic pg, input logic clr,
                               input logic [4:0] exp, input int n);
      vec_t v;
      v.on_req = on_req;
      v.pg     = pg;
      v.clr    = clr;
      v.exp    = exp;
      for (int k = 0; k < n; k++) vecs.push_back(v);
   endfunction

   initial begin
      checks = 0;
      errors = 0;

      // edge-by-edge table; comment gives edge numbers
      add(1, 0, 0, o_busy, 3);  // 1-3   PWR_UP
      add(1, 1, 0, o_busy, 8);  // 4-11  SETTLE
      add(1, 1, 0, o_on,   8);  // 12-19 ON
      add(0, 1, 0, o_busy, 1);  // 20    DRAIN, isolation back on
      add(1, 1, 0, o_busy, 3);  // 21-23 re-request ignored in DRAIN
      add(0, 1, 0, o_dn,   2);  // 24-25 PWR_DN, power cut
      add(0, 0, 0, o_off,  2);  // 26-27 OFF
      add(1, 0, 0, o_busy, 1);  // 28    PWR_UP
      add(1, 1, 0, o_busy, 5);  // 29-33 SETTLE count 7..3
      add(1, 0, 0, o_busy, 1);  // 34    glitch -> PWR_UP
      add(1, 1, 0, o_busy, 8);  // 35-42 full settle again
      add(1, 1, 0, o_on,   1);  // 43    ON
      add(1, 1, 1, o_on,   1);  // 44    err_clr ignored in ON
      add(1, 0, 0, o_err,  2);  // 45-46 pg loss in ON -> ERR, held
      add(1, 0, 1, o_off,  1);  // 47    clear -> OFF
      add(1, 0, 0, o_busy, 1);  // 48    request still up -> PWR_UP at once
      add(0, 0, 0, o_dn,   1);  // 49    drop in PWR_UP -> PWR_DN
      add(0, 0, 0, o_off,  1);  // 50    OFF
      add(1, 0, 0, o_busy, 1);  // 51    PWR_UP
      add(1, 1, 0, o_busy, 1);  // 52    SETTLE
      add(0, 1, 0, o_dn,   2);  // 53-54 drop in SETTLE -> PWR_DN
      add(0, 0, 0, o_off,  1);  // 55    OFF
      add(1, 1, 0, o_busy, 1);  // 56    PWR_UP
      add(1, 1, 0, o_busy, 8);  // 57-64 SETTLE
      add(1, 1, 0, o_on,   1);  // 65    ON
      add(0, 1, 0, o_busy, 1);  // 66    DRAIN
      add(0, 0, 0, o_err,  1);  // 67    pg loss in DRAIN -> ERR
      add(0, 0, 1, o_off,  1);  // 68    clear -> OFF
      add(0, 0, 1, o_off,  1);  // 69    err_clr in OFF stays OFF

      // reset
      rst = 1'b1;
      drive(0, 0, 0);
      #1;
      chk("reset_state", outs(), o_off);
      repeat (2) step();
      chk("reset_held", outs(), o_off);
      rst = 1'b0;

      foreach (vecs[i]) begin
         drive(vecs[i].on_req, vecs[i].pg, vecs[i].clr);
         step();
         chk($sformatf("vec_edge_%0d", i + 1), outs(), vecs[i].exp);
      end

      // asynchronous reset mid-ON with request and power-good still high
      drive(1, 1, 0);
      repeat (10) step();
      chk("pre_reset_on", outs(), o_on);
      #2;
      rst = 1'b1;
      #1;
      chk("async_reset_mid_on", outs(), o_off);
      step();
      chk("reset_over_edge", outs(), o_off);
      #2;
      rst = 1'b0;
      step();
      chk("post_reset_pwr_up", outs(), o_busy);
      step();
      chk("post_reset_settle", outs(), o_busy);
      drive(0, 1, 0);
      step();
      chk("post_reset_pwr_dn", outs(), o_dn);
      drive(0, 0, 0);
      step();
      chk("post_reset_off", outs(), o_off);

      // pg_i never rises while powering up
      drive(1, 0, 0);
      step();
      chk("to_pwr_up", outs(), o_busy);
`ifdef BSG_LEVEL_SHIFT_ISO_CTRL_TIMEOUT_EN
      for (int k = 1; k < 16; k++) begin
         step();
         chk($sformatf("timeout_wait_%0d", k), outs(), o_busy);
      end
      step();
      chk("timeout_err", outs(), o_err);
      drive(1, 0, 1);
      step();
      chk("timeout_clr_off", outs(), o_off);
      drive(1, 0, 0);
      step();
      chk("timeout2_pwr_up", outs(), o_busy);
      repeat (15) step();
      chk("timeout2_last_wait", outs(), o_busy);
      drive(1, 1, 0);
      step();
      chk("pg_beats_timeout", outs(), o_busy);
      drive(0, 1, 0);
      step();
      chk("pg_beats_timeout_dn", outs(), o_dn);
      drive(0, 0, 0);
      step();
      chk("pg_beats_timeout_off", outs(), o_off);
`else
      repeat (1000) step();
      chk("no_timeout_1000", outs(), o_busy);
      drive(0, 0, 0);
      step();
      chk("no_timeout_dn", outs(), o_dn);
      step();
      chk("no_timeout_off", outs(), o_off);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
